// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: one 17-bit XNOR LFSR polynomial and seed for generator and
// checker, plus the checker's synchronisation state encoding.
package prbs_pkg;

    localparam int unsigned       PRBS_N     = 17;
    localparam int unsigned       PRBS_TAP_A = 13;
    localparam int unsigned       PRBS_TAP_B = 16;
    localparam logic [PRBS_N-1:0] PRBS_SEED  = 17'h4b;

    typedef enum logic {
        SEARCH,
        LOCKED
    } prbs_state_t;

endpackage

// File: rtl/prbs_hist_reg.sv
// PRBS checker history shift register (h[0] newest) with next-bit predictor and
// dead-state (all-ones) detection.
module prbs_hist_reg
    import prbs_pkg::*;
#(
    parameter int unsigned N     = PRBS_N,
    parameter int unsigned TAP_A = PRBS_TAP_A,
    parameter int unsigned TAP_B = PRBS_TAP_B
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_en,
    input  logic sel_pred,
    input  logic bit_in,
    output logic p,
    output logic all_ones
);

    logic [N-1:0] hist_q;

    assign p        = ~(hist_q[TAP_A] ^ hist_q[TAP_B]);
    assign all_ones = &hist_q;

    // While locked the history is fed from the predictor, so a line error cannot
    // propagate into later predictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (shift_en) begin
            hist_q <= {hist_q[N-2:0], (sel_pred ? p : bit_in)};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises to the 17-bit XNOR LFSR msb stream, then counts
// bit errors. Defining PRBS_CHK_BIT_CNT_EN adds bit_count (locked samples compared) for BER.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned N           = PRBS_N,
    parameter int unsigned TAP_A       = PRBS_TAP_A,
    parameter int unsigned TAP_B       = PRBS_TAP_B,
    parameter int unsigned LOCK_CNT    = 32,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHK_BIT_CNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned FILL_W  = $clog2(N + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW);
    localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(N);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(LOSS_THRESH);

    prbs_state_t        state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d, werr_sum;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               err_pulse_d, sync_lost_d;
    logic               shift_en, sel_pred, p, all_ones, mismatch;
`ifdef PRBS_CHK_BIT_CNT_EN
    logic [31:0]        bit_count_q, bit_count_d;
`endif

    prbs_hist_reg #(
        .N     (N),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .sel_pred (sel_pred),
        .bit_in   (bit_in),
        .p        (p),
        .all_ones (all_ones)
    );

    assign mismatch  = bit_in ^ p;
    assign werr_sum  = werr_q + WERR_W'(mismatch);
    assign locked    = (state_q == LOCKED);
    assign err_count = err_count_q;
`ifdef PRBS_CHK_BIT_CNT_EN
    assign bit_count = bit_count_q;
`endif

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        sync_lost_d = 1'b0;
        shift_en    = 1'b0;
        sel_pred    = 1'b0;
`ifdef PRBS_CHK_BIT_CNT_EN
        bit_count_d = bit_count_q;
`endif
        if (bit_en) begin
            shift_en = 1'b1;
            case (state_q)
                SEARCH: begin
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                    end else if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        match_d = '0;
                        state_d = LOCKED;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    sel_pred = 1'b1;
`ifdef PRBS_CHK_BIT_CNT_EN
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
`endif
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
                    // Loss of sync wins over window wrap; an error on the last sample of
                    // a window still belongs to that window.
                    if (werr_sum == WERR_LIMIT || all_ones) begin
                        state_d     = SEARCH;
                        sync_lost_d = 1'b1;
                        fill_d      = '0;
                        match_d     = '0;
                        win_d       = '0;
                        werr_d      = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_sum;
                    end
                end
            endcase
        end
        if (clr_cnt) begin
            err_count_d = '0;
`ifdef PRBS_CHK_BIT_CNT_EN
            bit_count_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_count_q <= '0;
            err_pulse   <= 1'b0;
            sync_lost   <= 1'b0;
`ifdef PRBS_CHK_BIT_CNT_EN
            bit_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_count_q <= err_count_d;
            err_pulse   <= err_pulse_d;
            sync_lost   <= sync_lost_d;
`ifdef PRBS_CHK_BIT_CNT_EN
            bit_count_q <= bit_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus a randomized run against a
// queue-based behavioural model of the receive checker.
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_en = 1'b0;
    logic        bit_in = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse, sync_lost;
    logic [15:0] err_count;
`ifdef PRBS_CHK_BIT_CNT_EN
    logic [31:0] bit_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int n_pulse = 0;
    int n_lost = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .bit_in    (bit_in),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .sync_lost (sync_lost),
        .err_count (err_count)
`ifdef PRBS_CHK_BIT_CNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    // Generator: msb of a left-shifting XNOR LFSR with taps 13/16.
    bit [16:0] g;
    function automatic bit gen_bit();
        bit b;
        b = g[16];
        g = {g[15:0], ~(g[13] ^ g[16])};
        return b;
    endfunction

    // Reference checker: received history as a queue (index 0 newest), plain counters.
    bit m_h[$];
    bit m_lock, m_pulse, m_lost;
    int m_fill, m_match, m_wpos, m_werr, m_err;
    longint m_bits;

    function automatic void model_reset();
        m_h.delete();
        for (int i = 0; i < 17; i++) m_h.push_back(1'b0);
        m_lock = 0; m_pulse = 0; m_lost = 0;
        m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_err = 0; m_bits = 0;
    endfunction

    function automatic void model_step(bit en, bit b, bit clr);
        bit pred, miss;
        int ones;
        m_pulse = 0;
        m_lost  = 0;
        if (en) begin
            pred = ~(m_h[13] ^ m_h[16]);
            miss = (b != pred);
            ones = 0;
            foreach (m_h[i]) ones += int'(m_h[i]);
            m_h.push_front(m_lock ? pred : b);
            void'(m_h.pop_back());
            if (!m_lock) begin
                if (m_fill < 17) m_fill++;
                else if (miss) m_match = 0;
                else begin
                    m_match++;
                    if (m_match == 32) begin
                        m_lock = 1; m_match = 0; m_wpos = 0; m_werr = 0;
                    end
                end
            end else begin
                if (m_bits < 64'hFFFF_FFFF) m_bits++;
                if (miss) begin
                    m_pulse = 1;
                    if (m_err < 65535) m_err++;
                    m_werr++;
                end
                m_wpos++;
                if (m_werr == 8 || ones == 17) begin
                    m_lock = 0; m_lost = 1; m_fill = 0; m_match = 0;
                end else if (m_wpos == 64) begin
                    m_wpos = 0; m_werr = 0;
                end
            end
        end
        if (clr) begin
            m_err = 0;
            m_bits = 0;
        end
    endfunction

    task automatic cycle(input bit en, input bit b, input bit clr);
        bit_en  = en;
        bit_in  = b;
        clr_cnt = clr;
        @(posedge clk);
        model_step(en, b, clr);
        #1;
        n_pulse += int'(err_pulse);
        n_lost  += int'(sync_lost);
    endtask

    task automatic reset_dut();
        bit_en = 0; bit_in = 0; clr_cnt = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        g = PRBS_SEED;
        n_pulse = 0;
        n_lost = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests_run++;
        if ({locked, err_pulse, sync_lost} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 000", {locked, err_pulse, sync_lost});
        end
        tests_run++;
        if (err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_err_count: got %0d, expected 0", err_count);
        end
`ifdef PRBS_CHK_BIT_CNT_EN
        tests_run++;
        if (bit_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_bit_count: got %0d, expected 0", bit_count);
        end
`endif
    endtask

    task automatic test_lock();
        int n = 0;
        while (locked !== 1'b1 && n < 200) begin
            cycle(1, gen_bit(), 0);
            n++;
        end
        tests_run++;
        if (n != 49) begin
            tests_failed++;
            $display("FAIL lock_latency: got %0d samples, expected 49", n);
        end
        repeat (4000) cycle(1, gen_bit(), 0);
        tests_run++;
        if (locked !== 1'b1 || err_count !== 16'd0 || n_pulse != 0) begin
            tests_failed++;
            $display("FAIL clean_stream: got locked=%b err_count=%0d pulses=%0d, expected 1/0/0",
                     locked, err_count, n_pulse);
        end
    endtask

    task automatic test_single_error();
        n_pulse = 0;
        cycle(1, ~gen_bit(), 0);
        repeat (20) cycle(1, gen_bit(), 0);
        tests_run++;
        if (n_pulse != 1 || err_count !== 16'd1 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_error: got pulses=%0d err_count=%0d locked=%b, expected 1/1/1",
                     n_pulse, err_count, locked);
        end
    endtask

    task automatic test_loss_of_sync();
        bit [39:0] mask = '0;
        int k = 0;
        int w = 0;
        int pos;
        int n = 0;
        while (m_wpos != 0 && w < 64) begin
            cycle(1, gen_bit(), 0);
            w++;
        end
        while (k < 8) begin
            pos = $urandom_range(39, 0);
            if (!mask[pos]) begin
                mask[pos] = 1'b1;
                k++;
            end
        end
        n_pulse = 0; n_lost = 0; k = 0;
        for (int i = 0; i < 40 && k < 8; i++) begin
            if (mask[i]) begin
                cycle(1, ~gen_bit(), 0);
                k++;
            end else begin
                cycle(1, gen_bit(), 0);
            end
        end
        tests_run++;
        if (sync_lost !== 1'b1 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL loss_transition: got sync_lost=%b locked=%b, expected 1/0", sync_lost, locked);
        end
        tests_run++;
        if (err_count !== 16'd9 || n_pulse != 8 || n_lost != 1) begin
            tests_failed++;
            $display("FAIL loss_counts: got err_count=%0d pulses=%0d lost=%0d, expected 9/8/1",
                     err_count, n_pulse, n_lost);
        end
        while (locked !== 1'b1 && n < 200) begin
            cycle(1, gen_bit(), 0);
            n++;
        end
        tests_run++;
        if (n != 49 || err_count !== 16'd9) begin
            tests_failed++;
            $display("FAIL relock: got %0d samples err_count=%0d, expected 49/9", n, err_count);
        end
    endtask

    task automatic test_bit_en_duty();
        int ns = 0;
        reset_dut();
        for (int i = 0; i < 600 && locked !== 1'b1; i++) begin
            if (i % 3 == 0) begin
                cycle(1, gen_bit(), 0);
                ns++;
            end else begin
                cycle(0, 1'($urandom), 0);
            end
        end
        tests_run++;
        if (ns != 49) begin
            tests_failed++;
            $display("FAIL duty_lock: got %0d enabled samples, expected 49", ns);
        end
        n_pulse = 0; n_lost = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 2) cycle(1, gen_bit(), 0);
            else            cycle(0, 1'($urandom), 0);
        end
        tests_run++;
        if (locked !== 1'b1 || err_count !== 16'd0 || n_pulse != 0 || n_lost != 0) begin
            tests_failed++;
            $display("FAIL duty_idle: got locked=%b err_count=%0d pulses=%0d lost=%0d, expected 1/0/0/0",
                     locked, err_count, n_pulse, n_lost);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, ~gen_bit(), 0);
            repeat (3) cycle(1, gen_bit(), 0);
        end
        tests_run++;
        if (err_count !== 16'd5 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: got err_count=%0d locked=%b, expected 5/1", err_count, locked);
        end
        #2 rst_n = 0;
        #1;
        tests_run++;
        if ({locked, err_pulse, sync_lost} !== 3'b000 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got flags=%b err_count=%0d, expected 000/0",
                     {locked, err_pulse, sync_lost}, err_count);
        end
    endtask

    task automatic test_clr_cnt();
        int n = 0;
        reset_dut();
        while (locked !== 1'b1 && n < 200) begin
            cycle(1, gen_bit(), 0);
            n++;
        end
        repeat (5) cycle(1, gen_bit(), 0);
        cycle(1, ~gen_bit(), 1);
        tests_run++;
        if (err_count !== 16'd0 || err_pulse !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_vs_error: got err_count=%0d err_pulse=%b, expected 0/1", err_count, err_pulse);
        end
`ifdef PRBS_CHK_BIT_CNT_EN
        tests_run++;
        if (bit_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL clr_bit_count: got %0d, expected 0", bit_count);
        end
`endif
        repeat (10) cycle(1, gen_bit(), 0);
        cycle(1, ~gen_bit(), 0);
        tests_run++;
        if (err_count !== 16'd1 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_clr_error: got err_count=%0d locked=%b, expected 1/1", err_count, locked);
        end
`ifdef PRBS_CHK_BIT_CNT_EN
        tests_run++;
        if (bit_count !== 32'd11) begin
            tests_failed++;
            $display("FAIL bit_count_incr: got %0d, expected 11", bit_count);
        end
`endif
    endtask

    task automatic test_lockup();
        reset_dut();
        repeat (49) cycle(1, 1'b1, 0);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL ones_lock: got locked=%b, expected 1", locked);
        end
        cycle(1, 1'b1, 0);
        tests_run++;
        if (sync_lost !== 1'b1 || locked !== 1'b0 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL lockup_guard: got sync_lost=%b locked=%b err_count=%0d, expected 1/0/0",
                     sync_lost, locked, err_count);
        end
    endtask

    task automatic test_random();
        int unsigned denom [5] = '{1000, 40, 6, 200, 1000};
        bit en, b, clr;
        logic [18:0] got, exp;
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(3, 0) != 0);
            clr = ($urandom_range(199, 0) == 0);
            if (en) begin
                b = gen_bit();
                if ($urandom_range(denom[i / 600] - 1, 0) == 0) b = ~b;
            end else begin
                b = 1'($urandom);
            end
            cycle(en, b, clr);
            got = {locked, err_pulse, sync_lost, err_count};
            exp = {m_lock, m_pulse, m_lost, 16'(m_err)};
`ifdef PRBS_CHK_BIT_CNT_EN
            if (bit_count !== 32'(m_bits)) exp = ~got;
`endif
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random_cycle_%0d: got {locked,pulse,lost,cnt}=%h, expected %h", i, got, exp);
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_of_sync();
        test_bit_en_duty();
        test_async_reset();
        test_clr_cnt();
        test_lockup();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
